// File: rtl/dual_port_mem_client.sv
`default_nettype none
// ============================================================================
// Module   : dual_port_mem_client
// Brief    : Front end for a 4-entry 2R1W memory. It takes one write stream and
//            two read streams, defers reads that collide with a same-cycle
//            write, and holds each read response until it is consumed.
// Revision : 1.0 - initial release
// ============================================================================
module dual_port_mem_client #(
  parameter int DATA_WIDTH = 32,
  localparam int DW = 2 * (DATA_WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_req_valid,
  output logic          wr_req_ready,
  input  logic [1:0]    wr_req_addr,
  input  logic [DW-1:0] wr_req_data,
  input  logic          rd1_req_valid,
  output logic          rd1_req_ready,
  input  logic [1:0]    rd1_req_addr,
  output logic          rd1_rsp_valid,
  input  logic          rd1_rsp_ready,
  output logic [DW-1:0] rd1_rsp_data,
  input  logic          rd2_req_valid,
  output logic          rd2_req_ready,
  input  logic [1:0]    rd2_req_addr,
  output logic          rd2_rsp_valid,
  input  logic          rd2_rsp_ready,
  output logic [DW-1:0] rd2_rsp_data,
  output logic          mem_w_en,
  output logic [1:0]    mem_w_addr,
  output logic [DW-1:0] mem_w_data,
  output logic          mem_r_en1,
  output logic [1:0]    mem_r_addr1,
  input  logic [DW-1:0] mem_r_data1,
  output logic          mem_r_en2,
  output logic [1:0]    mem_r_addr2,
  input  logic [DW-1:0] mem_r_data2
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_defer = 2'd1;
  localparam logic [1:0] c_st_capt  = 2'd2;
  localparam logic [1:0] c_st_resp  = 2'd3;

  logic r_init;
  logic w_wr_fire;

  logic          w_req_valid [2];
  logic [1:0]    w_req_addr  [2];
  logic          w_rsp_ready [2];
  logic [DW-1:0] w_mem_rdata [2];
  logic          w_req_ready [2];
  logic          w_rsp_valid [2];
  logic [DW-1:0] w_rsp_data  [2];
  logic          w_mem_ren   [2];
  logic [1:0]    w_mem_raddr [2];

  always_ff @(posedge clk) begin
    if (!rst_n) r_init <= 1'b0;
    else        r_init <= 1'b1;
  end

  // Writes are never stalled once out of reset; they land at the accepting edge.
  assign w_wr_fire    = wr_req_valid & r_init;
  assign wr_req_ready = r_init;
  assign mem_w_en     = w_wr_fire;
  assign mem_w_addr   = wr_req_addr;
  assign mem_w_data   = wr_req_data;

  assign w_req_valid[0] = rd1_req_valid;
  assign w_req_valid[1] = rd2_req_valid;
  assign w_req_addr[0]  = rd1_req_addr;
  assign w_req_addr[1]  = rd2_req_addr;
  assign w_rsp_ready[0] = rd1_rsp_ready;
  assign w_rsp_ready[1] = rd2_rsp_ready;
  assign w_mem_rdata[0] = mem_r_data1;
  assign w_mem_rdata[1] = mem_r_data2;

  assign rd1_req_ready = w_req_ready[0];
  assign rd2_req_ready = w_req_ready[1];
  assign rd1_rsp_valid = w_rsp_valid[0];
  assign rd2_rsp_valid = w_rsp_valid[1];
  assign rd1_rsp_data  = w_rsp_data[0];
  assign rd2_rsp_data  = w_rsp_data[1];
  assign mem_r_en1     = w_mem_ren[0];
  assign mem_r_en2     = w_mem_ren[1];
  assign mem_r_addr1   = w_mem_raddr[0];
  assign mem_r_addr2   = w_mem_raddr[1];

  generate
    for (genvar p = 0; p < 2; p++) begin : g_rd_port
      logic [1:0]    r_state;
      logic [1:0]    w_state_nxt;
      logic [1:0]    r_addr;
      logic [DW-1:0] r_data;
      logic          w_fire;
      logic          w_hazard;
      logic          w_blocked;
      logic          w_rdy;
      logic          w_ren;
      logic [1:0]    w_raddr;
      logic          w_rvalid;

      assign w_fire    = w_req_valid[p] & r_init & (r_state == c_st_idle);
      assign w_hazard  = w_fire & w_wr_fire & (w_req_addr[p] == wr_req_addr);
      // A deferred read keeps waiting while the same address is being rewritten.
      assign w_blocked = w_wr_fire & (r_addr == wr_req_addr);

      always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
      end

      // Memory zeroes its output when only the other port reads, so capture
      // strictly in the cycle right after our own read.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_addr <= '0;
          r_data <= '0;
        end else begin
          if (w_hazard)                r_addr <= w_req_addr[p];
          if (r_state == c_st_capt)    r_data <= w_mem_rdata[p];
        end
      end

      always_comb begin
        w_state_nxt = r_state;
        case (r_state)
          c_st_idle:  if (w_fire) w_state_nxt = w_hazard ? c_st_defer : c_st_capt;
          c_st_defer: if (!w_blocked) w_state_nxt = c_st_capt;
          c_st_capt:  w_state_nxt = c_st_resp;
          c_st_resp:  if (w_rsp_ready[p]) w_state_nxt = c_st_idle;
          default:    w_state_nxt = c_st_idle;
        endcase
      end

      always_comb begin
        w_rdy    = 1'b0;
        w_ren    = 1'b0;
        w_raddr  = r_addr;
        w_rvalid = 1'b0;
        case (r_state)
          c_st_idle: begin
            w_rdy = r_init;
            if (w_fire && !w_hazard) begin
              w_ren   = 1'b1;
              w_raddr = w_req_addr[p];
            end
          end
          c_st_defer: if (!w_blocked) w_ren = 1'b1;
          c_st_resp:  w_rvalid = 1'b1;
          default:    ;
        endcase
      end

      assign w_req_ready[p] = w_rdy;
      assign w_mem_ren[p]   = w_ren;
      assign w_mem_raddr[p] = w_raddr;
      assign w_rsp_valid[p] = w_rvalid;
      assign w_rsp_data[p]  = r_data;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dual_port_mem_client.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_port_mem_client
// Brief    : Directed and randomised scoreboard bench for dual_port_mem_client
//            with a 2R1W memory device model attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_port_mem_client;
  localparam int DATA_WIDTH = 32;
  localparam int DW = 2 * (DATA_WIDTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_req_valid = 1'b0;
  logic          wr_req_ready;
  logic [1:0]    wr_req_addr = '0;
  logic [DW-1:0] wr_req_data = '0;
  logic [1:0]    rd_req_valid = '0;
  logic [1:0]    rd_req_ready;
  logic [1:0]    rd_req_addr [2] = '{default: '0};
  logic [1:0]    rd_rsp_valid;
  logic [1:0]    rd_rsp_ready = 2'b11;
  logic [DW-1:0] rd_rsp_data [2];
  logic          mem_w_en;
  logic [1:0]    mem_w_addr;
  logic [DW-1:0] mem_w_data;
  logic [1:0]    mem_r_en;
  logic [1:0]    mem_r_addr [2];
  logic [DW-1:0] mem_r_data [2] = '{default: '0};

  dual_port_mem_client #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .rd1_req_valid(rd_req_valid[0]), .rd1_req_ready(rd_req_ready[0]),
    .rd1_req_addr(rd_req_addr[0]), .rd1_rsp_valid(rd_rsp_valid[0]),
    .rd1_rsp_ready(rd_rsp_ready[0]), .rd1_rsp_data(rd_rsp_data[0]),
    .rd2_req_valid(rd_req_valid[1]), .rd2_req_ready(rd_req_ready[1]),
    .rd2_req_addr(rd_req_addr[1]), .rd2_rsp_valid(rd_rsp_valid[1]),
    .rd2_rsp_ready(rd_rsp_ready[1]), .rd2_rsp_data(rd_rsp_data[1]),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_r_en1(mem_r_en[0]), .mem_r_addr1(mem_r_addr[0]), .mem_r_data1(mem_r_data[0]),
    .mem_r_en2(mem_r_en[1]), .mem_r_addr2(mem_r_addr[1]), .mem_r_data2(mem_r_data[1])
  );

  always #5 clk = ~clk;

  // Memory device: registered reads return pre-write contents, and a port
  // that is idle while the other one reads sees zero.
  logic [DW-1:0] mem [4] = '{default: '0};
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (mem_r_en[p])          mem_r_data[p] <= mem[mem_r_addr[p]];
      else if (mem_r_en[1 - p]) mem_r_data[p] <= '0;
    end
    if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
  end

  // Reference model: shadow contents plus a queue of expected responses.
  typedef struct { int port; logic [DW-1:0] data; int due; } exp_t;
  exp_t          sbq [$];
  logic [DW-1:0] shadow [4] = '{default: '0};
  bit            pend [2] = '{default: 1'b0};
  logic [1:0]    paddr [2] = '{default: '0};
  bit            in_resp [2] = '{default: 1'b0};
  logic [DW-1:0] held [2] = '{default: '0};
  bit            rst_seen = 1'b0;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    bit wf, busy, fire, haz, res, init_exp;
    int idx;
    cyc++;
    init_exp = rst_seen;
    wf = wr_req_valid && init_exp;
    chk("wr_req_ready", DW'(wr_req_ready), DW'(init_exp));
    chk("mem_w_en", DW'(mem_w_en), DW'(wf));
    if (!rst_seen) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("rd%0d_rsp_valid_reset", p + 1), DW'(rd_rsp_valid[p]), '0);
        chk($sformatf("rd%0d_rsp_data_reset", p + 1), rd_rsp_data[p], '0);
      end
    end
    if (!rst_n) begin
      sbq.delete();
      for (int p = 0; p < 2; p++) begin
        pend[p] = 1'b0;
        in_resp[p] = 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        busy = pend[p] || in_resp[p];
        foreach (sbq[i]) if (sbq[i].port == p) busy = 1'b1;
        chk($sformatf("rd%0d_req_ready", p + 1), DW'(rd_req_ready[p]), DW'(init_exp && !busy));

        if (rd_rsp_valid[p]) begin
          if (!in_resp[p]) begin
            idx = -1;
            foreach (sbq[i]) if (sbq[i].port == p && idx < 0) idx = i;
            if (idx < 0) begin
              chk($sformatf("rd%0d_rsp_valid_unexpected", p + 1), DW'(rd_rsp_valid[p]), '0);
            end else begin
              chk($sformatf("rd%0d_rsp_data", p + 1), rd_rsp_data[p], sbq[idx].data);
              chk($sformatf("rd%0d_rsp_latency", p + 1), DW'(cyc), DW'(sbq[idx].due));
              held[p] = sbq[idx].data;
              sbq.delete(idx);
              in_resp[p] = 1'b1;
            end
          end else begin
            chk($sformatf("rd%0d_rsp_hold", p + 1), rd_rsp_data[p], held[p]);
          end
          if (rd_rsp_ready[p]) in_resp[p] = 1'b0;
        end else if (in_resp[p]) begin
          chk($sformatf("rd%0d_rsp_valid_dropped", p + 1), DW'(rd_rsp_valid[p]), DW'(1));
          in_resp[p] = 1'b0;
        end

        res  = pend[p] && !(wf && wr_req_addr == paddr[p]);
        fire = rd_req_valid[p] && init_exp && !busy;
        haz  = fire && wf && (wr_req_addr == rd_req_addr[p]);
        chk($sformatf("mem_r_en%0d", p + 1), DW'(mem_r_en[p]), DW'(res || (fire && !haz)));
        if (res) begin
          chk($sformatf("mem_r_addr%0d", p + 1), DW'(mem_r_addr[p]), DW'(paddr[p]));
          sbq.push_back('{p, shadow[paddr[p]], cyc + 2});
          pend[p] = 1'b0;
        end
        if (fire && !haz) begin
          chk($sformatf("mem_r_addr%0d", p + 1), DW'(mem_r_addr[p]), DW'(rd_req_addr[p]));
          sbq.push_back('{p, shadow[rd_req_addr[p]], cyc + 2});
        end
        if (haz) begin
          pend[p] = 1'b1;
          paddr[p] = rd_req_addr[p];
        end
      end
      if (wf) shadow[wr_req_addr] = wr_req_data;
    end
    rst_seen = rst_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    wr_req_valid = 1'b0;
    rd_req_valid = '0;
    repeat (n) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [DW-1:0] d);
    wr_req_valid = 1'b1;
    wr_req_addr  = a;
    wr_req_data  = d;
  endtask

  task automatic rd(input int p, input logic [1:0] a);
    rd_req_valid[p] = 1'b1;
    rd_req_addr[p]  = a;
  endtask

  initial begin
    logic [7:0]  init_v [4];
    logic [95:0] r;
    bit          acc [2];
    int          w;
    init_v = '{8'h00, 8'h11, 8'h22, 8'h33};
    acc = '{default: 1'b0};

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      wr(2'(a), DW'(init_v[a]));
      tick();
    end
    idle(1);

    // Write then read the same address one cycle later.
    wr(2'd2, DW'(12'h155)); tick();
    wr_req_valid = 1'b0; rd(0, 2'd2); tick();
    rd_req_valid = '0;
    @(negedge clk);
    chk("rd2_rsp_valid_during_capt", DW'(rd_rsp_valid[1]), '0);
    tick();
    @(negedge clk);
    chk("tp1_rd1_rsp_valid", DW'(rd_rsp_valid[0]), DW'(1));
    chk("tp1_rd1_rsp_data", rd_rsp_data[0], DW'(12'h155));
    idle(3);

    // Same-cycle write/read hazard on port 2.
    wr(2'd1, DW'(8'hAA)); rd(1, 2'd1);
    @(negedge clk);
    chk("tp2_mem_r_en2_deferred", DW'(mem_r_en[1]), '0);
    tick();
    wr_req_valid = 1'b0; rd_req_valid = '0;
    @(negedge clk);
    chk("tp2_mem_r_en2_issued", DW'(mem_r_en[1]), DW'(1));
    tick(); tick();
    @(negedge clk);
    chk("tp2_rd2_rsp_valid", DW'(rd_rsp_valid[1]), DW'(1));
    chk("tp2_rd2_rsp_data", rd_rsp_data[1], DW'(8'hAA));
    idle(3);

    // Three back-to-back writes keep port 1 deferred.
    wr(2'd3, DW'(12'h301)); rd(0, 2'd3); tick();
    rd_req_valid = '0;
    wr(2'd3, DW'(12'h302)); tick();
    wr(2'd3, DW'(12'h303)); tick();
    idle(8);

    // Both ports read address 0; port 1 then stalls its response.
    rd_rsp_ready = 2'b10;
    rd(0, 2'd0); rd(1, 2'd0); tick();
    rd_req_valid = '0; tick();
    @(negedge clk);
    chk("tp4_both_rsp_valid", DW'(rd_rsp_valid), DW'(2'b11));
    tick();
    rd(1, 2'd1);
    @(negedge clk);
    chk("tp4_rd1_req_ready_stalled", DW'(rd_req_ready[0]), '0);
    chk("tp4_rd2_req_ready", DW'(rd_req_ready[1]), DW'(1));
    tick();
    rd_req_valid = '0;
    tick(); tick(); tick();
    rd_rsp_ready = 2'b11;
    idle(4);

    // Reset while port 1 is capturing and port 2 holds a response.
    rd_rsp_ready = 2'b00;
    rd(1, 2'd2); tick();
    rd_req_valid = '0; rd(0, 2'd3); tick();
    rd_req_valid = '0; rst_n = 1'b0; tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("tp5_rsp_valid", DW'(rd_rsp_valid), '0);
    chk("tp5_req_ready", DW'(rd_req_ready), '0);
    chk("tp5_mem_r_en", DW'(mem_r_en), '0);
    tick();
    rd_rsp_ready = 2'b11;
    @(negedge clk);
    chk("tp5_rd_req_ready_release", DW'(rd_req_ready), DW'(2'b11));
    chk("tp5_wr_req_ready_release", DW'(wr_req_ready), DW'(1));
    tick();

    // Randomised traffic; read requests stay put until accepted.
    for (int n = 0; n < 600; n++) begin
      wr_req_valid = ($urandom_range(0, 1) == 1);
      wr_req_addr  = 2'($urandom_range(0, 3));
      r = {$urandom, $urandom, $urandom};
      wr_req_data  = r[DW-1:0];
      for (int p = 0; p < 2; p++) begin
        if (!rd_req_valid[p] || acc[p]) begin
          rd_req_valid[p] = ($urandom_range(0, 2) != 0);
          rd_req_addr[p]  = 2'($urandom_range(0, 3));
        end
        rd_rsp_ready[p] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int p = 0; p < 2; p++) acc[p] = rd_req_valid[p] && rd_req_ready[p];
      tick();
    end

    wr_req_valid = 1'b0;
    rd_req_valid = '0;
    rd_rsp_ready = 2'b11;
    w = 0;
    while ((sbq.size() != 0 || pend[0] || pend[1] || in_resp[0] || in_resp[1]) && w < 30) begin
      tick();
      w++;
    end
    @(negedge clk);
    chk("drain_outstanding", DW'(sbq.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
